instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Fetch stage that sits directly upstream of the single-cycle `Datapath`. It owns the program counter, issues word reads to a synchronous instruction memory, and buffers returned instructions in a small FIFO. It presents them to decode with a valid/ready handshake and flushes on a taken-branch redirect from the execute side. It decouples instruction-memory latency from datapath stalls so the datapath can later move off its combinational `InstructionMemory`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, 2..16).
- `RESET_PC`, 16'h000A: PC after reset; matches the datapath's boot address.

Ports:
- `Clock`  in  1  single clock, all state on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ImemReq`  out  1  read request this cycle.
- `ImemAddr`  out  16  byte address of the request; bit 0 always 0.
- `ImemData`  in  16  read data, valid exactly one cycle after an accepted request.
- `Redirect`  in  1  taken BEQ / PC override, single-cycle pulse.
- `RedirectPC`  in  16  target address; bit 0 ignored (forced 0).
- `InstrValid`  out  1  head entry available.
- `InstrReady`  in  1  decode consumes head when `InstrValid & InstrReady`.
- `Instr`  out  16  head instruction word.
- `InstrPC`  out  16  address the head was fetched from (for `pc4`/branch-target arithmetic).

## Operation
- State: `pc` (16b), FIFO of `{PC, word}` pairs, `count` (0..DEPTH), `inflight` (1b), `inflight_pc` (16b), `discard` (1b).
- Issue rule: `ImemReq = ~Reset & ~Redirect & (count + inflight) < DEPTH`. `ImemAddr = pc`. On issue: `pc <= pc + 2`, `inflight <= 1`, `inflight_pc <= pc`; otherwise `inflight <= 0`.
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000, no flag.
- Response: in the cycle after an issue, `ImemData` is pushed with `inflight_pc` unless `discard` is set. Space is guaranteed by the issue rule, so no overflow is possible.
- Pop: on `InstrValid & InstrReady`, the head is removed. Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo DEPTH.
- Redirect, with highest priority:
  - The FIFO is emptied (`count <= 0`, pointers reset).
  - `pc <= {RedirectPC[15:1],1'b0}`.
  - No request is issued that cycle.
  - If a response is due next cycle, `discard <= 1` so it is dropped. A pop coinciding with `Redirect` still completes (decode already took it). A response arriving in the redirect cycle itself is dropped.
- `Instr`/`InstrPC` hold the head entry. They are 0 when empty and `FETCH_BYPASS_EN` is off.

## Timing
- Reset values: `ImemReq`=0, `ImemAddr`=`RESET_PC`, `InstrValid`=0, `Instr`=0, `InstrPC`=0, `count`=0, `inflight`=0, `discard`=0.
- First request: in the first cycle after `Reset` deasserts, with address `RESET_PC`.
- Latency without bypass: request at cycle N, data at N+1, `InstrValid` at N+2.
- Steady state: one instruction per cycle while `InstrReady`=1.
- Back-pressure: with `InstrReady`=0, requests stop once `count + inflight = DEPTH`. The FIFO then holds exactly DEPTH entries and `ImemReq` stays 0 until a pop.
- Redirect at cycle R: request to the target at R+1. First target instruction `InstrValid` at R+3 (R+2 with bypass).
- Reset asserted mid-operation: all outputs return to their reset values asynchronously, and in-flight data is lost.

## Configuration
- `FETCH_BYPASS_EN` defined: when `count`=0 and a non-discarded response arrives, `InstrValid`=1 in that same cycle, with `Instr`=`ImemData` and `InstrPC`=`inflight_pc`. If it is also popped, it is not written to the FIFO. Request-to-valid latency is 1 cycle.
- Undefined: every response goes through the FIFO, with a 2-cycle latency. Outputs are purely registered/FIFO-read.

## Test plan
- Reset release, `InstrReady`=1, memory returns `addr ^ 16'h1234`: requests at 000A, 000C, 000E…; first `InstrValid` 2 cycles later with `Instr`=123E, `InstrPC`=000A, then one per cycle.
- `InstrReady`=0 for 10 cycles, DEPTH=4: exactly 4 requests (000A–0010), `count`=4, `ImemReq`=0. Releasing Ready drains 000A, 000C, 000E, 0010 in order with no gaps.
- `Redirect` with `RedirectPC`=0x0041 while 3 entries are queued and 1 request is in flight: FIFO emptied, in-flight word never appears, next request to 0x0040, next delivered `InstrPC`=0x0040.
- `Redirect` to 0xFFFC with `InstrReady`=1: delivered PCs FFFC, FFFE, 0000, 0002 (wrap-around).
- Pop and push in the same cycle with `count`=DEPTH-1: `count` unchanged, order preserved. `Reset` pulsed mid-stream: `InstrValid` drops immediately, then restarts at 000A.
- With `FETCH_BYPASS_EN`: empty FIFO, `InstrReady`=1, first `InstrValid` 1 cycle after the first request. Without it: 2 cycles.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, reads a synchronous imem, queues {pc,word} pairs for decode; FETCH_BYPASS_EN forwards an empty-queue response directly.
// Latency: request N, data N+1, InstrValid N+2 (N+1 with FETCH_BYPASS_EN).
// Backpressure: InstrReady low stops requests once queued plus in-flight words reach DEPTH.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h000A
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic [15:0] ImemData,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [15:0] Instr,
  output logic [15:0] InstrPC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic          inflight;
  logic          discard;
  logic [15:0]   pc;
  logic [15:0]   inflight_pc;
  logic          fifo_empty;
  logic          resp_vld;
  logic          pop;
  logic          pop_fifo;
  logic          push;

  assign fifo_empty = (count == '0);
  assign occupancy  = count + CW'(inflight);
  assign ImemReq    = ~Reset & ~Redirect & (occupancy < CW'(DEPTH));
  assign ImemAddr   = pc;
  // A response landing in the redirect cycle belongs to the old path.
  assign resp_vld   = inflight & ~discard & ~Redirect;

  always_comb begin
    head       = '0;
    InstrValid = 1'b0;
    if (!fifo_empty) begin
      head       = fifo_mem[rd_ptr];
      InstrValid = 1'b1;
    end
`ifdef FETCH_BYPASS_EN
    else if (resp_vld) begin
      head       = {inflight_pc, ImemData};
      InstrValid = 1'b1;
    end
`endif
  end

  assign Instr    = head.word;
  assign InstrPC  = head.pc;
  assign pop      = InstrValid & InstrReady;
  assign pop_fifo = pop & ~fifo_empty;

`ifdef FETCH_BYPASS_EN
  assign push = resp_vld & ~(fifo_empty & pop);
`else
  assign push = resp_vld;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else if (Redirect) begin
      pc       <= RedirectPC & 16'hFFFE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      // No request issues during a redirect, so nothing new is due next cycle.
      discard  <= ImemReq;
    end else begin
      discard <= 1'b0;
      if (ImemReq) begin
        pc          <= pc + 16'd2;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fifo) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop_fifo) count <= count + CW'(1);
      else if (pop_fifo && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_pc, ImemData};
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed fetch/backpressure/redirect/reset cases, then random traffic against an address-stream scoreboard.
module tb_instruction_fetch_queue;

  localparam logic [15:0] RESET_PC = 16'h000A;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ImemReq;
  logic [15:0] ImemAddr;
  logic [15:0] ImemData;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] Instr;
  logic [15:0] InstrPC;

  int          tests = 0;
  int          fails = 0;
  int          delivered = 0;
  logic        last_req = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] next_pc;
  logic [15:0] mon_exp;
  logic [15:0] exp_q[$];

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Reset(Reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemData(ImemData), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at +1 after the edge, update the expected stream at +7.
  task automatic step(input bit rst, input bit rdy, input bit rd, input logic [15:0] tgt);
    @(posedge Clock);
    #1;
    Reset      = rst;
    ImemData   = last_req ? (last_addr ^ 16'h1234) : 16'($urandom);
    InstrReady = rdy;
    Redirect   = rd;
    RedirectPC = tgt;
    #6;
    if (rst) begin
      exp_q.delete();
      next_pc = RESET_PC;
    end else if (rd) begin
      exp_q.delete();
      next_pc = {tgt[15:1], 1'b0};
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 16'd2;
    end
  endtask

  // Monitor: memory model capture plus scoreboard pop on every handshake.
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        last_req  = 1'b0;
        last_addr = '0;
      end else begin
        last_req  = ImemReq;
        last_addr = ImemAddr;
        if (ImemReq) check("imem_addr_even", 32'(ImemAddr[0]), 32'd0);
        if (InstrValid && InstrReady) begin
          delivered++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got pc %h with nothing expected", InstrPC);
          end else begin
            mon_exp = exp_q.pop_front();
            check("instr_pc", 32'(InstrPC), 32'(mon_exp));
            check("instr_word", 32'(Instr), 32'(mon_exp ^ 16'h1234));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int d0;
    int r;
    Reset = 1'b1; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = '0; ImemData = '0;
    next_pc = RESET_PC;
    #3;
    check("rst_imemreq", 32'(ImemReq), 32'd0);
    check("rst_imemaddr", 32'(ImemAddr), 32'(RESET_PC));
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_instr", 32'(Instr), 32'd0);
    check("rst_instrpc", 32'(InstrPC), 32'd0);

    // Reset release with decode always ready
    step(0, 1, 0, 16'h0);
    check("first_req", 32'(ImemReq), 32'd1);
    check("first_addr", 32'(ImemAddr), 32'h000A);
    step(0, 1, 0, 16'h0);
    check("lat_n1_valid", 32'(InstrValid), 32'(BYP));
    check("second_addr", 32'(ImemAddr), 32'h000C);
    step(0, 1, 0, 16'h0);
    check("lat_n2_valid", 32'(InstrValid), 32'd1);
    check("lat_n2_pc", 32'(InstrPC), BYP ? 32'h000C : 32'h000A);
    repeat (6) begin
      step(0, 1, 0, 16'h0);
      check("steady_valid", 32'(InstrValid), 32'd1);
    end

    // Mid-stream reset, then backpressure fill and drain
    step(1, 1, 0, 16'h0);
    check("midrst_valid", 32'(InstrValid), 32'd0);
    check("midrst_req", 32'(ImemReq), 32'd0);
    check("midrst_addr", 32'(ImemAddr), 32'(RESET_PC));
    step(0, 0, 0, 16'h0);
    nreq = int'(ImemReq);
    repeat (9) begin
      step(0, 0, 0, 16'h0);
      nreq += int'(ImemReq);
    end
    check("bp_req_count", 32'(nreq), 32'd4);
    check("bp_req_idle", 32'(ImemReq), 32'd0);
    check("bp_head_pc", 32'(InstrPC), 32'h000A);
    repeat (4) begin
      step(0, 1, 0, 16'h0);
      check("drain_valid", 32'(InstrValid), 32'd1);
    end

    // Redirect with three queued and one in flight
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    repeat (3) step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0041);
    check("redir_no_req", 32'(ImemReq), 32'd0);
    step(0, 1, 0, 16'h0);
    check("redir_req", 32'(ImemReq), 32'd1);
    check("redir_addr", 32'(ImemAddr), 32'h0040);
    check("redir_empty", 32'(InstrValid), 32'd0);
    step(0, 1, 0, 16'h0);
    check("redir_r2_valid", 32'(InstrValid), 32'(BYP));
    step(0, 1, 0, 16'h0);
    check("redir_r3_valid", 32'(InstrValid), 32'd1);
    check("redir_r3_pc", 32'(InstrPC), BYP ? 32'h0042 : 32'h0040);

    // Redirect near the top of the address space while flowing
    repeat (3) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'hFFFC);
    step(0, 1, 0, 16'h0);
    check("wrap_addr0", 32'(ImemAddr), 32'hFFFC);
    step(0, 1, 0, 16'h0);
    check("wrap_addr1", 32'(ImemAddr), 32'hFFFE);
    step(0, 1, 0, 16'h0);
    check("wrap_addr2", 32'(ImemAddr), 32'h0000);
    repeat (5) step(0, 1, 0, 16'h0);

    // Random traffic
    d0 = delivered;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) step(1, 1'b0, 1'b0, 16'h0);
      else step(0, ($urandom_range(0, 9) < 7), (r < 60), 16'($urandom));
    end
    check("liveness", 32'(delivered - d0 > 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
